// File: rtl/mult_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mult_arbiter_pkg
// Shared defines for the multiplier arbiter slice: the state encoding of the
// external 4-bit multiplier controller (estado_t), the arbiter state type
// (arb_state_t), the default watchdog timeout and a small grant helper.
// ---------------------------------------------------------------------------
package mult_arbiter_pkg;

    // Multiplier controller states, as published by the shared multiplier.
    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_COMPUTE_BIT_0 = 3'd1,
        ST_COMPUTE_BIT_1 = 3'd2,
        ST_COMPUTE_BIT_2 = 3'd3,
        ST_COMPUTE_BIT_3 = 3'd4,
        ST_END           = 3'd5
    } estado_t;

    // Arbiter states.
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_BUSY    = 3'd1,
        ARB_DONE    = 3'd2,
        ARB_ERROR   = 3'd3,
        ARB_RELEASE = 3'd4
    } arb_state_t;

    // Default maximum number of cycles spent in ARB_BUSY before aborting.
    localparam int ARB_TIMEOUT_DEFAULT = 15;

    // One-hot grant vector for a requester index (0 or 1).
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage : mult_arbiter_pkg

// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
// Round-robin arbiter sharing one external 4-bit x 4-bit multiplier between
// two requesters. The winner's operands are latched and presented to the
// multiplier; the product is captured when the multiplier reaches ST_END, or
// the operation is aborted by a watchdog after ARB_TIMEOUT busy cycles.
// Every output is a register.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   req_i[1:0]   level requests, held until done_o[k] or err_o[k]
//   a0_i, b0_i   requester-0 operands
//   a1_i, b1_i   requester-1 operands
//   gnt_o[1:0]   one-hot grant, held for the whole owned operation
//   done_o[1:0]  one-cycle completion pulse to the owner
//   err_o[1:0]   one-cycle timeout-abort pulse to the owner
//   prod_o[7:0]  last product, held until the next completion
//   mul_en_o     enable to the multiplier controller
//   mul_a_o/b_o  latched operands to the multiplier datapath
//   mul_state_i  multiplier controller state
//   mul_p_i      multiplier product, valid in ST_END
// ---------------------------------------------------------------------------
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int ARB_TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [3:0] a0_i,
    input  logic [3:0] b0_i,
    input  logic [3:0] a1_i,
    input  logic [3:0] b1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [1:0] err_o,
    output logic [7:0] prod_o,
    output logic       mul_en_o,
    output logic [3:0] mul_a_o,
    output logic [3:0] mul_b_o,
    input  estado_t    mul_state_i,
    input  logic [7:0] mul_p_i
);

    // Watchdog is just wide enough to hold ARB_TIMEOUT.
    localparam int                WDOG_W     = $clog2(ARB_TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(ARB_TIMEOUT);

    arb_state_t        state, state_n;
    logic [1:0]        gnt_n;
    logic [1:0]        done_n;
    logic [1:0]        err_n;
    logic [7:0]        prod_n;
    logic              mul_en_n;
    logic [3:0]        mul_a_n;
    logic [3:0]        mul_b_n;
    logic [WDOG_W-1:0] wdog, wdog_n, wdog_inc;
    logic              last_owner, last_owner_n;
    logic              winner;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ARB_IDLE;
            gnt_o      <= 2'b00;
            done_o     <= 2'b00;
            err_o      <= 2'b00;
            prod_o     <= 8'd0;
            mul_en_o   <= 1'b0;
            mul_a_o    <= 4'd0;
            mul_b_o    <= 4'd0;
            wdog       <= '0;
            // Pretend requester 1 was served last so requester 0 wins a tie.
            last_owner <= 1'b1;
        end else begin
            state      <= state_n;
            gnt_o      <= gnt_n;
            done_o     <= done_n;
            err_o      <= err_n;
            prod_o     <= prod_n;
            mul_en_o   <= mul_en_n;
            mul_a_o    <= mul_a_n;
            mul_b_o    <= mul_b_n;
            wdog       <= wdog_n;
            last_owner <= last_owner_n;
        end
    end

    always_comb begin
        state_n      = state;
        gnt_n        = gnt_o;
        done_n       = 2'b00;
        err_n        = 2'b00;
        prod_n       = prod_o;
        mul_en_n     = mul_en_o;
        mul_a_n      = mul_a_o;
        mul_b_n      = mul_b_o;
        wdog_n       = wdog;
        last_owner_n = last_owner;
        wdog_inc     = wdog + 1'b1;

        // Round-robin pick: a lone requester wins outright; on a tie the
        // requester that was not served last wins.
        if (req_i == 2'b11) begin
            winner = ~last_owner;
        end else begin
            winner = req_i[1];
        end

        case (state)
            ARB_IDLE: begin
                if (req_i != 2'b00) begin
                    state_n  = ARB_BUSY;
                    gnt_n    = owner_onehot(winner);
                    mul_a_n  = winner ? a1_i : a0_i;
                    mul_b_n  = winner ? b1_i : b0_i;
                    mul_en_n = 1'b1;
                    wdog_n   = '0;
                end
            end
            ARB_BUSY: begin
                // A finished product takes priority over a coincident timeout.
                if (mul_state_i == ST_END) begin
                    state_n  = ARB_DONE;
                    prod_n   = mul_p_i;
                    done_n   = gnt_o;
                    mul_en_n = 1'b0;
                end else if (wdog_inc == WDOG_LIMIT) begin
                    state_n  = ARB_ERROR;
                    err_n    = gnt_o;
                    mul_en_n = 1'b0;
                    wdog_n   = wdog_inc;
                end else begin
                    wdog_n   = wdog_inc;
                end
            end
            ARB_DONE, ARB_ERROR: begin
                state_n = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                // Keep ownership until the multiplier is back at rest so a
                // new grant never lands on a busy controller.
                if (mul_state_i == ST_IDLE) begin
                    state_n      = ARB_IDLE;
                    gnt_n        = 2'b00;
                    last_owner_n = gnt_o[1];
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter
// Self-checking bench for mult_arbiter. Contains a simple multiplier
// controller model, a transaction-level reference model of the arbiter that
// is compared against the DUT on every cycle, and directed scenarios with
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mult_arbiter;
    import mult_arbiter_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [3:0] a0_i  = 4'd0;
    logic [3:0] b0_i  = 4'd0;
    logic [3:0] a1_i  = 4'd0;
    logic [3:0] b1_i  = 4'd0;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic [1:0] err_o;
    logic [7:0] prod_o;
    logic       mul_en_o;
    logic [3:0] mul_a_o;
    logic [3:0] mul_b_o;
    estado_t    mul_state;
    logic [7:0] mul_p;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stuck_mode = 0;

    mult_arbiter #(.ARB_TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .a0_i        (a0_i),
        .b0_i        (b0_i),
        .a1_i        (a1_i),
        .b1_i        (b1_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .prod_o      (prod_o),
        .mul_en_o    (mul_en_o),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_state_i (mul_state),
        .mul_p_i     (mul_p)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Multiplier controller model: four compute steps then ST_END.
    // stuck_mode 1 parks it in ST_COMPUTE_BIT_2, stuck_mode 2 bails to idle.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mul_state <= ST_IDLE;
        end else begin
            case (mul_state)
                ST_IDLE:          if (mul_en_o) mul_state <= ST_COMPUTE_BIT_0;
                ST_COMPUTE_BIT_0: mul_state <= ST_COMPUTE_BIT_1;
                ST_COMPUTE_BIT_1: mul_state <= ST_COMPUTE_BIT_2;
                ST_COMPUTE_BIT_2: begin
                    if (stuck_mode == 0)      mul_state <= ST_COMPUTE_BIT_3;
                    else if (stuck_mode == 2) mul_state <= ST_IDLE;
                end
                ST_COMPUTE_BIT_3: mul_state <= ST_END;
                default:          mul_state <= ST_IDLE;
            endcase
        end
    end

    // Product is only meaningful in ST_END; show junk otherwise.
    assign mul_p = (mul_state == ST_END) ? (8'(mul_a_o) * 8'(mul_b_o)) : 8'hA5;

    // ---------------- reference model ----------------
    logic [1:0] m_gnt;
    logic [1:0] m_done;
    logic [1:0] m_err;
    logic [7:0] m_prod;
    logic       m_en;
    logic [3:0] m_a;
    logic [3:0] m_b;
    bit         m_owned;
    bit         m_working;
    bit         m_settle;
    int         m_owner;
    int         m_last;
    int         m_cycles;

    task automatic modelReset();
        m_gnt = 2'b00; m_done = 2'b00; m_err = 2'b00; m_prod = 8'd0;
        m_en = 1'b0; m_a = 4'd0; m_b = 4'd0;
        m_owned = 0; m_working = 0; m_settle = 0;
        m_owner = 0; m_last = 1; m_cycles = 0;
    endtask

    // One clock edge of the arbiter, in terms of ownership and progress.
    task automatic modelStep();
        m_done = 2'b00;
        m_err  = 2'b00;
        if (!m_owned) begin
            if (req_i != 2'b00) begin
                if (req_i == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
                else                m_owner = req_i[1] ? 1 : 0;
                m_owned   = 1;
                m_working = 1;
                m_cycles  = 0;
                m_en      = 1'b1;
                m_gnt     = 2'(1 << m_owner);
                m_a       = (m_owner == 1) ? a1_i : a0_i;
                m_b       = (m_owner == 1) ? b1_i : b0_i;
            end
        end else if (m_working) begin
            m_cycles++;
            if (mul_state == ST_END) begin
                m_prod = 8'(m_a) * 8'(m_b);
                m_done[m_owner] = 1'b1;
                m_en = 1'b0; m_working = 0; m_settle = 1;
            end else if (m_cycles == TIMEOUT) begin
                m_err[m_owner] = 1'b1;
                m_en = 1'b0; m_working = 0; m_settle = 1;
            end
        end else if (m_settle) begin
            m_settle = 0;
        end else if (mul_state == ST_IDLE) begin
            m_gnt   = 2'b00;
            m_owned = 0;
            m_last  = m_owner;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) modelReset();
            else        modelStep();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk_i) begin
        #1;
        checks++;
        if ({gnt_o, done_o, err_o, prod_o, mul_en_o, mul_a_o, mul_b_o} !==
            {m_gnt, m_done, m_err, m_prod, m_en, m_a, m_b}) begin
            failures++;
            $display("[TB] FAIL model_cycle%0d actual gnt=%b done=%b err=%b prod=%0d en=%b a=%0d b=%0d required gnt=%b done=%b err=%b prod=%0d en=%b a=%0d b=%0d",
                     cyc, gnt_o, done_o, err_o, prod_o, mul_en_o, mul_a_o, mul_b_o,
                     m_gnt, m_done, m_err, m_prod, m_en, m_a, m_b);
        end
    end

    // Grant monitor: records the owner and cycle of every new grant.
    int         grant_owner[$];
    int         grant_cycle[$];
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge clk_i) begin
        if (rst_i && gnt_o != 2'b00 && prev_gnt == 2'b00) begin
            grant_owner.push_back(gnt_o[1] ? 1 : 0);
            grant_cycle.push_back(cyc);
        end
        prev_gnt <= gnt_o;
    end

    // ---------------- tasks ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic [3:0] a1, input logic [3:0] b1);
        req_i = req; a0_i = a0; b0_i = b0; a1_i = a1; b1_i = b1;
    endtask

    function automatic bit waitCond(input int kind, input int k);
        case (kind)
            0:       return done_o[k] == 1'b1;
            1:       return err_o[k] == 1'b1;
            default: return gnt_o == 2'b00;
        endcase
    endfunction

    // Bounded wait, on negedges, for a done/err pulse or grant release.
    task automatic waitOutput(input string name, input int kind, input int k, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!waitCond(kind, k) && n < limit);
        checkOutput(name, 32'(waitCond(kind, k)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_gnt",  32'(gnt_o),    32'd0);
        checkOutput("reset_prod", 32'(prod_o),   32'd0);
        checkOutput("reset_en",   32'(mul_en_o), 32'd0);
        rst_i = 1'b1;

        // Single request 7 x 9.
        $display("[TB] scenario single request");
        @(negedge clk_i);
        applyStimulus(2'b01, 4'd7, 4'd9, 4'd0, 4'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t1_gnt_N",  32'(gnt_o),    32'd1);
        checkOutput("t1_en_N",   32'(mul_en_o), 32'd1);
        checkOutput("t1_mula_N", 32'(mul_a_o),  32'd7);
        repeat (5) @(negedge clk_i);
        checkOutput("t1_done_N5", 32'(done_o), 32'd0);
        @(negedge clk_i);
        checkOutput("t1_done_N6", 32'(done_o), 32'd1);
        checkOutput("t1_prod",    32'(prod_o), 32'd63);
        applyStimulus(2'b00, 4'd7, 4'd9, 4'd0, 4'd0);
        @(negedge clk_i);
        checkOutput("t1_gnt_N7", 32'(gnt_o), 32'd1);
        @(negedge clk_i);
        checkOutput("t1_gnt_N8", 32'(gnt_o), 32'd0);

        // Both requesting straight out of reset.
        $display("[TB] scenario tie from reset");
        rst_i = 1'b0;
        applyStimulus(2'b11, 4'd15, 4'd15, 4'd3, 4'd2);
        grant_owner.delete(); grant_cycle.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        waitOutput("t2_done0", 0, 0, 12, n);
        checkOutput("t2_prod0", 32'(prod_o), 32'd225);
        applyStimulus(2'b10, 4'd15, 4'd15, 4'd3, 4'd2);
        waitOutput("t2_done1", 0, 1, 20, n);
        checkOutput("t2_prod1", 32'(prod_o), 32'd6);
        applyStimulus(2'b00, 4'd15, 4'd15, 4'd3, 4'd2);
        waitOutput("t2_release", 2, 0, 10, n);
        checkOutput("t2_grants", 32'(grant_owner.size()), 32'd2);
        if (grant_owner.size() == 2) begin
            checkOutput("t2_first_owner", 32'(grant_owner[0]), 32'd0);
            checkOutput("t2_gap_ge9", 32'(grant_cycle[1] - grant_cycle[0] >= 9), 32'd1);
        end

        // Both held high for four operations.
        $display("[TB] scenario round robin");
        grant_owner.delete(); grant_cycle.delete();
        applyStimulus(2'b11, 4'd15, 4'd15, 4'd3, 4'd2);
        for (int i = 0; i < 4; i++) begin
            waitOutput($sformatf("t3_done_op%0d", i), 0, i % 2, 20, n);
            checkOutput($sformatf("t3_prod_op%0d", i), 32'(prod_o), (i % 2 == 0) ? 32'd225 : 32'd6);
        end
        applyStimulus(2'b00, 4'd15, 4'd15, 4'd3, 4'd2);
        waitOutput("t3_release", 2, 0, 10, n);
        checkOutput("t3_grants", 32'(grant_owner.size()), 32'd4);
        for (int i = 0; i < grant_owner.size(); i++) begin
            checkOutput($sformatf("t3_order%0d", i), 32'(grant_owner[i]), 32'(i % 2));
        end

        // Multiplier stuck: watchdog abort.
        $display("[TB] scenario timeout");
        stuck_mode = 1;
        applyStimulus(2'b01, 4'd5, 4'd3, 4'd0, 4'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t4_gnt_N", 32'(gnt_o), 32'd1);
        repeat (14) @(negedge clk_i);
        checkOutput("t4_err_N14", 32'(err_o),    32'd0);
        checkOutput("t4_en_N14",  32'(mul_en_o), 32'd1);
        @(negedge clk_i);
        checkOutput("t4_err_N15", 32'(err_o),    32'd1);
        checkOutput("t4_en_N15",  32'(mul_en_o), 32'd0);
        checkOutput("t4_prod",    32'(prod_o),   32'd6);
        applyStimulus(2'b00, 4'd5, 4'd3, 4'd0, 4'd0);
        repeat (3) @(negedge clk_i);
        checkOutput("t4_gnt_held", 32'(gnt_o), 32'd1);
        stuck_mode = 2;
        @(negedge clk_i);
        checkOutput("t4_gnt_wait", 32'(gnt_o), 32'd1);
        @(negedge clk_i);
        checkOutput("t4_gnt_clear", 32'(gnt_o), 32'd0);
        stuck_mode = 0;

        // Reset in the middle of an operation.
        $display("[TB] scenario reset mid operation");
        applyStimulus(2'b01, 4'd2, 4'd4, 4'd0, 4'd0);
        @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("t5_rst_outputs", 32'({gnt_o, done_o, err_o, prod_o, mul_en_o, mul_a_o, mul_b_o}), 32'd0);
        @(negedge clk_i);
        checkOutput("t5_rst_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd6, 4'd7);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t5_gnt", 32'(gnt_o), 32'd2);
        waitOutput("t5_done", 0, 1, 12, n);
        checkOutput("t5_latency", 32'(n),      32'd6);
        checkOutput("t5_prod",    32'(prod_o), 32'd42);
        applyStimulus(2'b00, 4'd0, 4'd0, 4'd6, 4'd7);
        waitOutput("t5_release", 2, 0, 10, n);

        // Owner withdraws its request early; a new request arrives mid-op.
        $display("[TB] scenario early request drop");
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd9, 4'd11);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("t6_gnt", 32'(gnt_o), 32'd2);
        @(negedge clk_i);
        applyStimulus(2'b00, 4'd0, 4'd0, 4'd15, 4'd0);
        @(negedge clk_i);
        applyStimulus(2'b01, 4'd1, 4'd1, 4'd15, 4'd0);
        waitOutput("t6_done1", 0, 1, 12, n);
        checkOutput("t6_latency", 32'(n),      32'd4);
        checkOutput("t6_prod",    32'(prod_o), 32'd99);
        waitOutput("t6_done0", 0, 0, 20, n);
        checkOutput("t6_prod0", 32'(prod_o), 32'd1);
        applyStimulus(2'b00, 4'd1, 4'd1, 4'd15, 4'd0);
        waitOutput("t6_release", 2, 0, 10, n);
        repeat (2) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_arbiter
